// File: rtl/rate_pkg.sv
// Shared types for the rate detector: speed codes, classification result,
// FSM states and nominal-period helpers.
package rate_pkg;

  typedef enum logic [1:0] {
    SPD_CLK = 2'b00,
    SPD_X1  = 2'b01,
    SPD_X2  = 2'b10,
    SPD_X4  = 2'b11
  } speed_t;

  typedef struct packed {
    logic   invalid;
    speed_t spd;
  } class_t;

  localparam class_t CLASS_INVALID = '{invalid: 1'b1, spd: SPD_CLK};

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MEASURE = 2'b01,
    LOCKED  = 2'b10
  } state_t;

  function automatic int unsigned nominal_period(speed_t s, int unsigned cf);
    case (s)
      SPD_CLK: return 1;
      SPD_X1:  return cf;
      SPD_X2:  return 2 * cf;
      default: return 4 * cf;
    endcase
  endfunction

  // Band test written without subtraction so small periods cannot wrap.
  function automatic logic within_tol(int unsigned p, int unsigned nom, int unsigned tol);
    return ((p + tol) >= nom) && (p <= (nom + tol));
  endfunction

endpackage

// File: rtl/rate_period_counter.sv
// Period counter: counts cycles between ticks, flags timeout and
// registers the measured period with a one-cycle valid pulse.
module rate_period_counter #(
  parameter int PW         = 7,
  parameter int MAX_PERIOD = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_tick,
  input  logic          i_measuring,
  output logic [PW-1:0] o_cnt,
  output logic [PW-1:0] o_period,
  output logic          o_period_valid,
  output logic          o_sample,
  output logic          o_timeout
);

  logic [PW-1:0] r_cnt;
  logic [PW-1:0] r_period;
  logic          r_period_valid;

  assign o_sample  = i_measuring & i_tick;
  assign o_timeout = i_measuring & ~i_tick & (r_cnt == PW'(MAX_PERIOD));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt          <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
    end else begin
      r_period_valid <= 1'b0;
      if (i_tick) begin
        // A tick from IDLE only starts the count; no period exists yet.
        r_cnt <= PW'(1);
        if (i_measuring) begin
          r_period       <= r_cnt;
          r_period_valid <= 1'b1;
        end
      end else if (o_timeout) begin
        r_cnt <= '0;
      end else if (i_measuring) begin
        r_cnt <= r_cnt + PW'(1);
      end
    end
  end

  assign o_cnt          = r_cnt;
  assign o_period       = r_period;
  assign o_period_valid = r_period_valid;

endmodule

// File: rtl/rate_detector.sv
// Rate detector top: classifies measured tick periods into speed codes and
// locks after LOCK_COUNT equal classifications. Optional LockEvent output
// is enabled with RATE_DETECTOR_IRQ_EN.
module rate_detector
  import rate_pkg::*;
#(
  parameter  int CLOCK_FREQUENCY = 500,
  parameter  int LOCK_COUNT      = 3,
  parameter  int TOLERANCE       = 0,
  localparam int MAX_PERIOD      = 4 * CLOCK_FREQUENCY + TOLERANCE,
  localparam int PW              = $clog2(MAX_PERIOD + 1) + 1
) (
  input  logic          ClockIn,
  input  logic          Reset,
  input  logic          Tick,
  output logic [PW-1:0] Period,
  output logic          PeriodValid,
  output logic [1:0]    Speed,
  output logic          Locked
`ifdef RATE_DETECTOR_IRQ_EN
  ,output logic         LockEvent
`endif
);

  localparam int MW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  state_t        r_state,  w_state_n;
  logic [MW-1:0] r_match,  w_match_n, w_match_inc;
  class_t        r_last,   w_last_n;
  logic          r_locked, w_locked_n;
  speed_t        r_speed,  w_speed_n;
  class_t        w_class;
  logic [PW-1:0] w_cnt;
  logic [31:0]   w_p32;
  logic          w_sample;
  logic          w_timeout;

  rate_period_counter #(
    .PW         (PW),
    .MAX_PERIOD (MAX_PERIOD)
  ) u_counter (
    .i_clk          (ClockIn),
    .i_rst          (Reset),
    .i_tick         (Tick),
    .i_measuring    (r_state != IDLE),
    .o_cnt          (w_cnt),
    .o_period       (Period),
    .o_period_valid (PeriodValid),
    .o_sample       (w_sample),
    .o_timeout      (w_timeout)
  );

  always_comb begin
    w_class = CLASS_INVALID;
    w_p32   = 32'(w_cnt);
    if (w_p32 == 32'd1)
      w_class = '{invalid: 1'b0, spd: SPD_CLK};
    else if (within_tol(w_p32, nominal_period(SPD_X1, CLOCK_FREQUENCY), TOLERANCE))
      w_class = '{invalid: 1'b0, spd: SPD_X1};
    else if (within_tol(w_p32, nominal_period(SPD_X2, CLOCK_FREQUENCY), TOLERANCE))
      w_class = '{invalid: 1'b0, spd: SPD_X2};
    else if (within_tol(w_p32, nominal_period(SPD_X4, CLOCK_FREQUENCY), TOLERANCE))
      w_class = '{invalid: 1'b0, spd: SPD_X4};
  end

  always_comb begin
    w_state_n   = r_state;
    w_match_n   = r_match;
    w_last_n    = r_last;
    w_locked_n  = r_locked;
    w_speed_n   = r_speed;
    w_match_inc = '0;
    case (r_state)
      IDLE: begin
        if (Tick) w_state_n = MEASURE;
      end
      default: begin
        if (w_timeout) begin
          w_state_n  = IDLE;
          w_locked_n = 1'b0;
          w_match_n  = '0;
          w_last_n   = CLASS_INVALID;
        end else if (w_sample) begin
          if (w_class.invalid)
            w_match_inc = '0;
          else if (w_class == r_last)
            w_match_inc = (r_match == MW'(LOCK_COUNT)) ? r_match : r_match + MW'(1);
          else
            w_match_inc = MW'(1);
          if ((w_class.invalid || (w_class != r_last)) && (r_state == LOCKED)) begin
            w_state_n  = MEASURE;
            w_locked_n = 1'b0;
          end
          w_match_n = w_match_inc;
          w_last_n  = w_class;
          if (w_match_inc == MW'(LOCK_COUNT)) begin
            w_state_n  = LOCKED;
            w_locked_n = 1'b1;
            w_speed_n  = w_class.spd;
          end
        end
      end
    endcase
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_match  <= '0;
      r_last   <= CLASS_INVALID;
      r_locked <= 1'b0;
      r_speed  <= SPD_CLK;
    end else begin
      r_state  <= w_state_n;
      r_match  <= w_match_n;
      r_last   <= w_last_n;
      r_locked <= w_locked_n;
      r_speed  <= w_speed_n;
    end
  end

  assign Speed  = r_speed;
  assign Locked = r_locked;

`ifdef RATE_DETECTOR_IRQ_EN
  logic r_lock_event;

  always_ff @(posedge ClockIn) begin
    if (Reset) r_lock_event <= 1'b0;
    else       r_lock_event <= w_locked_n ^ r_locked;
  end

  assign LockEvent = r_lock_event;
`endif

endmodule

// File: tb/tb_rate_detector.sv
// Directed bench for rate_detector (CF=8, LOCK_COUNT=3); a second instance
// with TOLERANCE=1 covers the tolerant classification case.
module tb_rate_detector;

  localparam int CF = 8;
  localparam int PW = $clog2(4 * CF + 0 + 1) + 1;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Tick = 1'b0;
  logic          Tick2 = 1'b0;
  logic [PW-1:0] Period, Period2;
  logic          PeriodValid, PeriodValid2;
  logic [1:0]    Speed, Speed2;
  logic          Locked, Locked2;
`ifdef RATE_DETECTOR_IRQ_EN
  logic          LockEvent, LockEvent2;
`endif

  always #5 clk = ~clk;

  rate_detector #(.CLOCK_FREQUENCY(CF), .LOCK_COUNT(3), .TOLERANCE(0)) dut (
    .ClockIn(clk), .Reset(Reset), .Tick(Tick), .Period(Period),
    .PeriodValid(PeriodValid), .Speed(Speed), .Locked(Locked)
`ifdef RATE_DETECTOR_IRQ_EN
    , .LockEvent(LockEvent)
`endif
  );

  rate_detector #(.CLOCK_FREQUENCY(CF), .LOCK_COUNT(3), .TOLERANCE(1)) dut2 (
    .ClockIn(clk), .Reset(Reset), .Tick(Tick2), .Period(Period2),
    .PeriodValid(PeriodValid2), .Speed(Speed2), .Locked(Locked2)
`ifdef RATE_DETECTOR_IRQ_EN
    , .LockEvent(LockEvent2)
`endif
  );

  typedef struct {
    int       gap;
    logic     tick;
    logic     pv;
    int       period;
    logic     locked;
    logic [1:0] speed;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic t, input logic r);
    Reset = r;
    Tick  = t;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic t);
    Tick2 = t;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int gap, input logic t, input logic pv, input int p,
                     input logic l, input logic [1:0] s);
    vec_t v;
    v.gap = gap; v.tick = t; v.pv = pv; v.period = p; v.locked = l; v.speed = s;
    vecs.push_back(v);
  endtask

  initial begin
    logic pv_seen;
    logic prev_locked;

    // gap zero-cycles, then one cycle with Tick = tick; expected after that edge
    add(0, 1, 0, 0, 0, 2'b00);    // IDLE start
    add(7, 1, 1, 8, 0, 2'b00);
    add(7, 1, 1, 8, 0, 2'b00);
    add(7, 1, 1, 8, 1, 2'b01);    // lock at x1
    add(31, 1, 1, 32, 0, 2'b01);  // class change drops lock, speed held
    add(31, 1, 1, 32, 0, 2'b01);
    add(31, 1, 1, 32, 1, 2'b11);
    add(15, 1, 1, 16, 0, 2'b11);
    add(15, 1, 1, 16, 0, 2'b11);
    add(15, 1, 1, 16, 1, 2'b10);
    add(30, 0, 0, 16, 1, 2'b10);  // cnt reaches 32, still locked
    add(0, 0, 0, 16, 0, 2'b10);   // timeout: back to IDLE, speed kept
    add(0, 1, 0, 16, 0, 2'b10);   // first tick after timeout: no period
    add(7, 1, 1, 8, 0, 2'b10);
    add(8, 1, 1, 9, 0, 2'b10);    // invalid period resets match
    add(7, 1, 1, 8, 0, 2'b10);
    add(7, 1, 1, 8, 0, 2'b10);
    add(7, 1, 1, 8, 1, 2'b01);
    add(0, 1, 1, 1, 0, 2'b01);    // held-high tick
    add(0, 1, 1, 1, 0, 2'b01);
    add(0, 1, 1, 1, 1, 2'b00);
    add(0, 1, 1, 1, 1, 2'b00);

    step(0, 1);
    step(0, 1);
    chk("rst_period", int'(Period), 0);
    chk("rst_pv", int'(PeriodValid), 0);
    chk("rst_speed", int'(Speed), 0);
    chk("rst_locked", int'(Locked), 0);
`ifdef RATE_DETECTOR_IRQ_EN
    chk("rst_lockevent", int'(LockEvent), 0);
`endif
    Reset = 1'b0;
    prev_locked = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      pv_seen = 1'b0;
      for (int g = 0; g < vecs[i].gap; g++) begin
        step(0, 0);
        pv_seen |= PeriodValid;
      end
      step(vecs[i].tick, 0);
      if (vecs[i].gap > 0) chk($sformatf("v%0d_gap_pv", i), int'(pv_seen), 0);
      chk($sformatf("v%0d_pv", i), int'(PeriodValid), int'(vecs[i].pv));
      chk($sformatf("v%0d_period", i), int'(Period), vecs[i].period);
      chk($sformatf("v%0d_locked", i), int'(Locked), int'(vecs[i].locked));
      chk($sformatf("v%0d_speed", i), int'(Speed), int'(vecs[i].speed));
`ifdef RATE_DETECTOR_IRQ_EN
      chk($sformatf("v%0d_lockevent", i), int'(LockEvent), int'(vecs[i].locked != prev_locked));
`endif
      prev_locked = vecs[i].locked;
    end

    // Reset mid-measurement with Tick high
    step(0, 0);
    step(0, 0);
    step(0, 0);
    step(1, 1);
    chk("midrst_period", int'(Period), 0);
    chk("midrst_pv", int'(PeriodValid), 0);
    chk("midrst_locked", int'(Locked), 0);
    chk("midrst_speed", int'(Speed), 0);
`ifdef RATE_DETECTOR_IRQ_EN
    chk("midrst_lockevent", int'(LockEvent), 0);
`endif
    step(1, 0);
    chk("post_rst_start_pv", int'(PeriodValid), 0);
    for (int g = 0; g < 7; g++) step(0, 0);
    step(1, 0);
    chk("post_rst_pv", int'(PeriodValid), 1);
    chk("post_rst_period", int'(Period), 8);
    chk("post_rst_locked", int'(Locked), 0);
    Tick = 1'b0;

    // Tolerant instance: periods 8, 9, 8 lock on the third period
    step2(1);
    chk("tol_start_pv", int'(PeriodValid2), 0);
    for (int g = 0; g < 7; g++) step2(0);
    step2(1);
    chk("tol_p1_period", int'(Period2), 8);
    chk("tol_p1_locked", int'(Locked2), 0);
    for (int g = 0; g < 8; g++) step2(0);
    step2(1);
    chk("tol_p2_period", int'(Period2), 9);
    chk("tol_p2_locked", int'(Locked2), 0);
    for (int g = 0; g < 7; g++) step2(0);
    step2(1);
    chk("tol_p3_period", int'(Period2), 8);
    chk("tol_p3_locked", int'(Locked2), 1);
    chk("tol_p3_speed", int'(Speed2), 1);
    step2(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
